// File: rtl/riscv_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem_arb_pkg
//  Brief    : Shared types and constants for the unified-memory I/D arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_arb_pkg;

    // Width of each performance counter
    localparam int PERF_W = 32;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

endpackage : riscv_mem_arb_pkg
`default_nettype wire

// File: rtl/riscv_arb_perf_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_arb_perf_ctr
//  Brief    : Three free-running wrap-around event counters (I grants,
//             D grants, conflict cycles) for the memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_arb_perf_ctr
    import riscv_mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              inc_d,
    input  logic              inc_conflict,
    output logic [PERF_W-1:0] i_cnt,
    output logic [PERF_W-1:0] d_cnt,
    output logic [PERF_W-1:0] conflict_cnt
);

    logic [PERF_W-1:0] r_i_cnt;
    logic [PERF_W-1:0] r_d_cnt;
    logic [PERF_W-1:0] r_conflict_cnt;

    // Count each event once per cycle; counters simply wrap on overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_cnt        <= '0;
            r_d_cnt        <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (inc_i)        r_i_cnt        <= r_i_cnt + PERF_W'(1);
            if (inc_d)        r_d_cnt        <= r_d_cnt + PERF_W'(1);
            if (inc_conflict) r_conflict_cnt <= r_conflict_cnt + PERF_W'(1);
        end
    end

    assign i_cnt        = r_i_cnt;
    assign d_cnt        = r_d_cnt;
    assign conflict_cnt = r_conflict_cnt;

endmodule : riscv_arb_perf_ctr
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem_arbiter
//  Brief    : Shares one single-ported byte-maskable memory between the
//             fetch (I) and load/store (D) ports. D has fixed priority; I wins
//             after STARVE_MAX consecutive losses. One access in flight,
//             with a new grant allowed in the cycle its response returns.
//             Optional performance counters: define RISCV_ARB_PERF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter
    import riscv_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // fetch port
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_W-1:0]     i_req_addr,
    output logic                  i_resp_valid,
    output logic [DATA_W-1:0]     i_resp_data,
    // load/store port
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_W-1:0]     d_req_addr,
    input  logic                  d_req_we,
    input  logic [DATA_W/8-1:0]   d_req_mask,
    input  logic [DATA_W-1:0]     d_req_wdata,
    output logic                  d_resp_valid,
    output logic [DATA_W-1:0]     d_resp_data,
    // memory side
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    // performance counters
    output logic [PERF_W-1:0]     perf_i_grants,
    output logic [PERF_W-1:0]     perf_d_grants,
    output logic [PERF_W-1:0]     perf_conflict
);

    localparam int c_cnt_w = $clog2(MEM_LAT + 1);
    localparam int c_stv_w = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load   = c_cnt_w'(MEM_LAT - 1);
    localparam logic [c_stv_w-1:0] c_starve_max = c_stv_w'(STARVE_MAX);

    arb_state_t          r_state,  w_state_nxt;
    arb_owner_t          r_owner,  w_owner_nxt;
    logic [c_cnt_w-1:0]  r_cnt,    w_cnt_nxt;
    logic [c_stv_w-1:0]  r_starve, w_starve_nxt;
    logic                r_store,  w_store_nxt;

    logic w_resp_now;
    logic w_can_issue;
    logic w_i_win;
    logic w_d_win;

    // State, owner, latency countdown and starvation tracking registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_owner  <= OWN_NONE;
            r_cnt    <= '0;
            r_starve <= '0;
            r_store  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_cnt    <= w_cnt_nxt;
            r_starve <= w_starve_nxt;
            r_store  <= w_store_nxt;
        end
    end

    // Arbitration, response return and memory drive; rst_n gates issue so
    // every output reads zero while reset is held
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_cnt_nxt    = r_cnt;
        w_starve_nxt = r_starve;
        w_store_nxt  = r_store;

        i_req_ready  = 1'b0;
        d_req_ready  = 1'b0;
        i_resp_valid = 1'b0;
        i_resp_data  = '0;
        d_resp_valid = 1'b0;
        d_resp_data  = '0;
        mem_en       = 1'b0;
        mem_we       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;

        w_resp_now  = (r_state == ARB_WAIT) && (r_cnt == '0);
        w_can_issue = rst_n && ((r_state == ARB_IDLE) || w_resp_now);
        w_i_win     = w_can_issue && i_req_valid &&
                      (!d_req_valid || (r_starve == c_starve_max));
        w_d_win     = w_can_issue && d_req_valid && !w_i_win;

        // Response for the access in flight; read data passes straight through
        if (w_resp_now) begin
            if (r_owner == OWN_I) begin
                i_resp_valid = 1'b1;
                i_resp_data  = mem_rdata;
            end else if (r_owner == OWN_D) begin
                d_resp_valid = 1'b1;
                d_resp_data  = r_store ? '0 : mem_rdata;
            end
            w_state_nxt = ARB_IDLE;
            w_owner_nxt = OWN_NONE;
        end else if (r_state == ARB_WAIT) begin
            w_cnt_nxt = r_cnt - c_cnt_w'(1);
        end

        // New grant may coincide with the response above
        if (w_i_win) begin
            i_req_ready = 1'b1;
            mem_en      = 1'b1;
            mem_addr    = i_req_addr;
            w_state_nxt = ARB_WAIT;
            w_owner_nxt = OWN_I;
            w_cnt_nxt   = c_cnt_load;
            w_store_nxt = 1'b0;
        end else if (w_d_win) begin
            d_req_ready = 1'b1;
            mem_en      = 1'b1;
            mem_addr    = d_req_addr;
            mem_wdata   = d_req_wdata;
            mem_we      = d_req_we ? d_req_mask : '0;
            w_state_nxt = ARB_WAIT;
            w_owner_nxt = OWN_D;
            w_cnt_nxt   = c_cnt_load;
            w_store_nxt = d_req_we;
        end

        // Consecutive I losses; cleared whenever I is idle or served
        if (!i_req_valid || w_i_win) begin
            w_starve_nxt = '0;
        end else if (w_d_win && (r_starve != c_starve_max)) begin
            w_starve_nxt = r_starve + c_stv_w'(1);
        end
    end

`ifdef RISCV_ARB_PERF_EN
    logic w_conflict;
    assign w_conflict = i_req_valid && d_req_valid && (w_i_win || w_d_win);

    riscv_arb_perf_ctr u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_i        (w_i_win),
        .inc_d        (w_d_win),
        .inc_conflict (w_conflict),
        .i_cnt        (perf_i_grants),
        .d_cnt        (perf_d_grants),
        .conflict_cnt (perf_conflict)
    );
`else
    assign perf_i_grants = '0;
    assign perf_d_grants = '0;
    assign perf_conflict = '0;
`endif

endmodule : riscv_mem_arbiter
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_mem_arbiter
//  Brief    : Randomized self-checking bench. Lane 0 runs MEM_LAT=1, lane 1
//             runs MEM_LAT=3; each lane has its own memory model and a
//             transaction-level reference of the arbitration rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // stimulus (driven by the bench)
    logic        i_req_valid [2];
    logic [31:0] i_req_addr  [2];
    logic        d_req_valid [2];
    logic [31:0] d_req_addr  [2];
    logic        d_req_we    [2];
    logic [3:0]  d_req_mask  [2];
    logic [31:0] d_req_wdata [2];
    logic [31:0] mem_rdata   [2];
    // DUT outputs
    logic        i_req_ready  [2];
    logic        i_resp_valid [2];
    logic [31:0] i_resp_data  [2];
    logic        d_req_ready  [2];
    logic        d_resp_valid [2];
    logic [31:0] d_resp_data  [2];
    logic        mem_en       [2];
    logic [3:0]  mem_we       [2];
    logic [31:0] mem_addr     [2];
    logic [31:0] mem_wdata    [2];
    logic [31:0] perf_i       [2];
    logic [31:0] perf_d       [2];
    logic [31:0] perf_c       [2];

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid[0]), .i_req_ready(i_req_ready[0]), .i_req_addr(i_req_addr[0]),
        .i_resp_valid(i_resp_valid[0]), .i_resp_data(i_resp_data[0]),
        .d_req_valid(d_req_valid[0]), .d_req_ready(d_req_ready[0]), .d_req_addr(d_req_addr[0]),
        .d_req_we(d_req_we[0]), .d_req_mask(d_req_mask[0]), .d_req_wdata(d_req_wdata[0]),
        .d_resp_valid(d_resp_valid[0]), .d_resp_data(d_resp_data[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .perf_i_grants(perf_i[0]), .perf_d_grants(perf_d[0]), .perf_conflict(perf_c[0])
    );

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(STARVE_MAX)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid[1]), .i_req_ready(i_req_ready[1]), .i_req_addr(i_req_addr[1]),
        .i_resp_valid(i_resp_valid[1]), .i_resp_data(i_resp_data[1]),
        .d_req_valid(d_req_valid[1]), .d_req_ready(d_req_ready[1]), .d_req_addr(d_req_addr[1]),
        .d_req_we(d_req_we[1]), .d_req_mask(d_req_mask[1]), .d_req_wdata(d_req_wdata[1]),
        .d_resp_valid(d_resp_valid[1]), .d_resp_data(d_resp_data[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .perf_i_grants(perf_i[1]), .perf_d_grants(perf_d[1]), .perf_conflict(perf_c[1])
    );

    // bookkeeping
    int checks;
    int failures;
    int cyc;
    int p_i;
    int p_d;
    bit drained;

    // memory model (what the SRAM macro holds) and read-return pipeline
    logic [31:0] sram    [2][64];
    bit          pipe_v  [2][3];
    logic [31:0] pipe_d  [2][3];

    // reference model state
    logic [31:0] ref_mem    [2][64];
    int          pend_cyc   [2];     // cycle the outstanding response is due, -1 if none
    bit          pend_d     [2];
    bit          pend_store [2];
    logic [31:0] pend_data  [2];
    int          starve     [2];
    bit          acc_i      [2];
    bit          acc_d      [2];
    int          n_i        [2];
    int          n_d        [2];
    int          n_c        [2];

    function automatic int lat(input int l);
        return (l == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] init_word(input int l, input int idx);
        return (32'h1000_0000 * l) ^ (idx * 32'h0101_0101) ^ 32'hC3A5_0F96;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            pend_cyc[l] = -1;
            starve[l]   = 0;
            acc_i[l]    = 1'b1;
            acc_d[l]    = 1'b1;
            n_i[l] = 0; n_d[l] = 0; n_c[l] = 0;
            for (int k = 0; k < 3; k++) pipe_v[l][k] = 1'b0;
            for (int k = 0; k < 64; k++) begin
                sram[l][k]    = init_word(l, k);
                ref_mem[l][k] = init_word(l, k);
            end
        end
    endtask

    task automatic check_all_zero(input int l);
        chk($sformatf("L%0d rst i_ready", l),  i_req_ready[l],  0);
        chk($sformatf("L%0d rst d_ready", l),  d_req_ready[l],  0);
        chk($sformatf("L%0d rst i_rvalid", l), i_resp_valid[l], 0);
        chk($sformatf("L%0d rst i_rdata", l),  i_resp_data[l],  0);
        chk($sformatf("L%0d rst d_rvalid", l), d_resp_valid[l], 0);
        chk($sformatf("L%0d rst d_rdata", l),  d_resp_data[l],  0);
        chk($sformatf("L%0d rst mem_en", l),   mem_en[l],       0);
        chk($sformatf("L%0d rst mem_we", l),   mem_we[l],       0);
        chk($sformatf("L%0d rst mem_addr", l), mem_addr[l],     0);
        chk($sformatf("L%0d rst mem_wd", l),   mem_wdata[l],    0);
        chk($sformatf("L%0d rst perf_i", l),   perf_i[l],       0);
        chk($sformatf("L%0d rst perf_d", l),   perf_d[l],       0);
        chk($sformatf("L%0d rst perf_c", l),   perf_c[l],       0);
    endtask

    // At the falling edge: compare outputs with the reference, then advance
    // the memory model and reference to the coming rising edge.
    task automatic check_and_model();
        for (int l = 0; l < 2; l++) begin
            bit          resp_now, can, iv, dv, iw, dw;
            logic [3:0]  e_we;
            logic [31:0] e_addr, e_wd;
            int          idx;
            resp_now = (pend_cyc[l] == cyc);
            can      = (pend_cyc[l] < 0) || resp_now;
            iv       = i_req_valid[l];
            dv       = d_req_valid[l];
            iw       = can && iv && (!dv || starve[l] == STARVE_MAX);
            dw       = can && dv && !iw;
            e_we     = (dw && d_req_we[l]) ? d_req_mask[l] : 4'h0;
            e_addr   = iw ? i_req_addr[l] : (dw ? d_req_addr[l] : 32'h0);
            e_wd     = dw ? d_req_wdata[l] : 32'h0;

            chk($sformatf("L%0d i_ready", l),  i_req_ready[l],  {31'b0, iw});
            chk($sformatf("L%0d d_ready", l),  d_req_ready[l],  {31'b0, dw});
            chk($sformatf("L%0d mem_en", l),   mem_en[l],       {31'b0, iw | dw});
            chk($sformatf("L%0d mem_we", l),   mem_we[l],       e_we);
            chk($sformatf("L%0d mem_addr", l), mem_addr[l],     e_addr);
            chk($sformatf("L%0d mem_wd", l),   mem_wdata[l],    e_wd);
            chk($sformatf("L%0d i_rvalid", l), i_resp_valid[l], {31'b0, resp_now && !pend_d[l]});
            chk($sformatf("L%0d d_rvalid", l), d_resp_valid[l], {31'b0, resp_now && pend_d[l]});
            if (resp_now && pend_d[l])
                chk($sformatf("L%0d d_rdata", l), d_resp_data[l], pend_store[l] ? 32'h0 : pend_data[l]);
            if (resp_now && !pend_d[l])
                chk($sformatf("L%0d i_rdata", l), i_resp_data[l], pend_data[l]);
`ifdef RISCV_ARB_PERF_EN
            chk($sformatf("L%0d perf_i", l), perf_i[l], n_i[l]);
            chk($sformatf("L%0d perf_d", l), perf_d[l], n_d[l]);
            chk($sformatf("L%0d perf_c", l), perf_c[l], n_c[l]);
`else
            chk($sformatf("L%0d perf_i", l), perf_i[l], 0);
            chk($sformatf("L%0d perf_d", l), perf_d[l], 0);
            chk($sformatf("L%0d perf_c", l), perf_c[l], 0);
`endif

            // memory model reacts to whatever the DUT actually drives
            pipe_v[l][2] = pipe_v[l][1]; pipe_d[l][2] = pipe_d[l][1];
            pipe_v[l][1] = pipe_v[l][0]; pipe_d[l][1] = pipe_d[l][0];
            pipe_v[l][0] = 1'b0;
            if (mem_en[l] === 1'b1) begin
                idx = int'(mem_addr[l][7:2]);
                for (int b = 0; b < 4; b++)
                    if (mem_we[l][b]) sram[l][idx][8*b +: 8] = mem_wdata[l][8*b +: 8];
                if (mem_we[l] == 4'h0) begin
                    pipe_v[l][0] = 1'b1;
                    pipe_d[l][0] = sram[l][idx];
                end
            end

            // reference advance
            if (resp_now) pend_cyc[l] = -1;
            if (iw || dw) begin
                pend_cyc[l]   = cyc + lat(l);
                pend_d[l]     = dw;
                pend_store[l] = dw && d_req_we[l];
                idx = iw ? int'(i_req_addr[l][7:2]) : int'(d_req_addr[l][7:2]);
                if (pend_store[l]) begin
                    for (int b = 0; b < 4; b++)
                        if (d_req_mask[l][b]) ref_mem[l][idx][8*b +: 8] = d_req_wdata[l][8*b +: 8];
                    pend_data[l] = 32'h0;
                end else begin
                    pend_data[l] = ref_mem[l][idx];
                end
            end
            if (!iv || iw)                            starve[l] = 0;
            else if (dw && starve[l] < STARVE_MAX)    starve[l] = starve[l] + 1;
            n_i[l] += int'(iw);
            n_d[l] += int'(dw);
            n_c[l] += int'((iw || dw) && iv && dv);
            acc_i[l] = iw;
            acc_d[l] = dw;
        end
    endtask

    // Just after the rising edge: present read data and update requesters,
    // which hold valid and payload until accepted.
    task automatic drive_next();
        for (int l = 0; l < 2; l++) begin
            logic [31:0] a;
            mem_rdata[l] = pipe_v[l][lat(l)-1] ? pipe_d[l][lat(l)-1] : $urandom;
            if (acc_i[l] || !i_req_valid[l]) begin
                a = $urandom; a[1:0] = 2'b00;
                i_req_valid[l] = ($urandom_range(0, 99) < p_i);
                i_req_addr[l]  = a;
            end
            if (acc_d[l] || !d_req_valid[l]) begin
                a = $urandom; a[1:0] = 2'b00;
                d_req_valid[l] = ($urandom_range(0, 99) < p_d);
                d_req_addr[l]  = a;
                d_req_we[l]    = $urandom_range(0, 1);
                d_req_mask[l]  = 4'($urandom);
                d_req_wdata[l] = $urandom;
            end
            acc_i[l] = 1'b0;
            acc_d[l] = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_and_model();
        @(posedge clk);
        #1;
        cyc++;
        drive_next();
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        p_i = 60; p_d = 50;
        for (int l = 0; l < 2; l++) begin
            i_req_valid[l] = 1'b1; i_req_addr[l] = 32'h4;
            d_req_valid[l] = 1'b1; d_req_addr[l] = 32'h100;
            d_req_we[l] = 1'b1; d_req_mask[l] = 4'b0011; d_req_wdata[l] = 32'hDEADBEEF;
            mem_rdata[l] = 32'hFFFF_FFFF;
        end
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) check_all_zero(l);
        rst_n = 1'b1;
        drive_next();

        // mixed random traffic
        repeat (600) step();

        // both requesters saturated: exercises the starvation override
        p_i = 100; p_d = 100;
        repeat (200) step();

        // drain, then reset in the middle of a MEM_LAT=3 load
        p_i = 0; p_d = 0;
        drained = 1'b0;
        for (int k = 0; k < 40 && !drained; k++) begin
            step();
            if (pend_cyc[1] < 0 && !i_req_valid[1] && !d_req_valid[1]) drained = 1'b1;
        end
        chk("L1 drain", {31'b0, drained}, 32'd1);
        d_req_valid[1] = 1'b1; d_req_addr[1] = 32'h40; d_req_we[1] = 1'b0;
        d_req_mask[1]  = 4'h0; d_req_wdata[1] = $urandom;
        step();                         // grant cycle T0
        #2;
        for (int l = 0; l < 2; l++) begin
            i_req_valid[l] = 1'b1;
            d_req_valid[l] = 1'b1;
        end
        rst_n = 1'b0;                   // mid T1
        #1;
        for (int l = 0; l < 2; l++) check_all_zero(l);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        rst_n = 1'b1;
        p_i = 50; p_d = 50;
        drive_next();
        repeat (400) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // absolute guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_riscv_mem_arbiter
`default_nettype wire
